pulse_cdc_arbiter: RTL and testbench

Multiplexes single-cycle event pulses from N_CH requesters in the clka_i domain onto one toggle-handshake CDC channel into the clkb_i domain. Per-channel pending counters absorb bursts. A round-robin scheduler launches one event at a time, then waits for the ack toggle to return before launching the next. This guarantees no pulse is lost to toggle aliasing. The clkb_i side delivers a one-cycle strobe plus the source channel index.

---
 rtl/pulse_cdc_arbiter_pkg.sv | 19 +
 rtl/pulse_cdc_arbiter_if.sv | 30 +++
 rtl/pulse_cdc_arbiter_toggle_handshake_sync.sv | 40 ++++
 rtl/pulse_cdc_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pulse_cdc_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_cdc_arbiter_pkg.sv
// Shared types and helpers for the pulse CDC arbiter slice.
package pulse_cdc_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Channel index width; never narrower than one bit so N_CH=1 still has a port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_cdc_arbiter_if.sv
// Request/status/event bundle of the pulse CDC arbiter; master drives requests.
interface pulse_cdc_arbiter_if
  import pulse_cdc_arbiter_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CH_W = ch_w(DEF_N_CH)
);

  // req_i is a fire-and-forget pulse per channel: no ready, every set cycle counts as
  // one event. evt_valid_o is a one-cycle strobe in clkb_i with evt_ch_o valid alongside.
  logic [N_CH-1:0] req_i;
  logic            ovf_clr_i;
  logic [N_CH-1:0] ovf_o;
  logic [N_CH-1:0] pend_o;
  logic            busy_o;
  logic            evt_valid_o;
  logic [CH_W-1:0] evt_ch_o;
  state_e          dbg_state_o;

  modport master (
    output req_i, ovf_clr_i,
    input  ovf_o, pend_o, busy_o, evt_valid_o, evt_ch_o, dbg_state_o
  );

  modport slave (
    input  req_i, ovf_clr_i,
    output ovf_o, pend_o, busy_o, evt_valid_o, evt_ch_o, dbg_state_o
  );

endinterface

// File: rtl/pulse_cdc_arbiter_toggle_handshake_sync.sv
// Two-direction toggle synchronizer: req toggle into clkb (with edge strobe), ack back into clka.
module toggle_handshake_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clka,
  input  logic i_clkb,
  input  logic i_arst_n,
  input  logic i_req_tgl,
  output logic o_evt,
  output logic o_ack_tgl
);

  logic [SYNC_STAGES-1:0] r_b_sync;
  logic                   r_b_hist;
  logic [SYNC_STAGES-1:0] r_a_sync;

  always_ff @(posedge i_clkb or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_b_sync <= '0;
      r_b_hist <= 1'b0;
    end else begin
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], i_req_tgl};
      r_b_hist <= r_b_sync[SYNC_STAGES-1];
    end
  end

  // Any change of the settled toggle is one event.
  assign o_evt = r_b_sync[SYNC_STAGES-1] ^ r_b_hist;

  always_ff @(posedge i_clka or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_a_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], r_b_sync[SYNC_STAGES-1]};
    end
  end

  assign o_ack_tgl = r_a_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_cdc_arbiter.sv
// Counts per-channel event pulses in clka_i and serialises them over a toggle CDC into clkb_i.
// Define PULSE_CDC_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module pulse_cdc_arbiter
  import pulse_cdc_arbiter_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clka_i,
  input  logic                arst_n_i,
  input  logic                clkb_i,
  pulse_cdc_arbiter_if.slave  io_bus
);

  localparam int CH_W = ch_w(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                      r_state;
  logic [N_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [N_CH-1:0]             r_ovf;
  logic [CH_W-1:0]             r_ch;
  logic                        r_req_tgl;
  logic                        r_evt_valid;
  logic [CH_W-1:0]             r_evt_ch;

  logic [N_CH-1:0]             w_pend;
  logic [N_CH-1:0]             w_grant;
  logic [N_CH-1:0]             w_inc;
  logic [N_CH-1:0]             w_dec;
  logic [N_CH-1:0]             w_ovf_set;
  logic                        w_any;
  logic [CH_W-1:0]             w_win;
  logic                        w_evt;
  logic                        w_ack_tgl;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_pend[c] = (r_cnt[c] != '0);
    end
  end

  assign w_any = |w_pend;

`ifdef PULSE_CDC_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_pend[i]) w_win = CH_W'(i);
    end
  end
`else
  logic [CH_W-1:0] r_ptr;
  logic [N_CH-1:0] w_rot;
  logic [CH_W-1:0] w_off;
  logic [CH_W:0]   w_sum;
  logic [CH_W:0]   w_nxt;

  // Rotate so the search always starts at bit 0, then map the offset back to a channel.
  assign w_rot = N_CH'({w_pend, w_pend} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = CH_W'(i);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= (CH_W+1)'(N_CH)) ? CH_W'(w_sum - (CH_W+1)'(N_CH))
                                            : w_sum[CH_W-1:0];
  assign w_nxt = {1'b0, w_win} + (CH_W+1)'(1);

  always_ff @(posedge clka_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_ptr <= (w_nxt >= (CH_W+1)'(N_CH)) ? '0 : w_nxt[CH_W-1:0];
    end
  end
`endif

  assign w_grant = (r_state == IDLE && w_any) ? (N_CH'(1) << w_win) : '0;

  // A request and a grant on the same channel cancel: the counter holds.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_inc[c]     = io_bus.req_i[c] & ~w_grant[c];
      w_dec[c]     = w_grant[c] & ~io_bus.req_i[c];
      w_ovf_set[c] = w_inc[c] & (r_cnt[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clka_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_inc[c] && !w_ovf_set[c]) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end else if (w_dec[c]) begin
          r_cnt[c] <= r_cnt[c] - CNT_W'(1);
        end
      end
      r_ovf <= (io_bus.ovf_clr_i ? '0 : r_ovf) | w_ovf_set;
    end
  end

  // r_ch is latched a cycle before the toggle and held until the ack returns,
  // so clkb may sample it directly when it sees the toggle.
  always_ff @(posedge clka_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_req_tgl <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ch    <= w_win;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_req_tgl <= ~r_req_tgl;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (w_ack_tgl == r_req_tgl) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  toggle_handshake_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clka    (clka_i),
    .i_clkb    (clkb_i),
    .i_arst_n  (arst_n_i),
    .i_req_tgl (r_req_tgl),
    .o_evt     (w_evt),
    .o_ack_tgl (w_ack_tgl)
  );

  always_ff @(posedge clkb_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
    end else begin
      r_evt_valid <= w_evt;
      if (w_evt) r_evt_ch <= r_ch;
    end
  end

  assign io_bus.ovf_o       = r_ovf;
  assign io_bus.pend_o      = w_pend;
  assign io_bus.busy_o      = (r_state != IDLE);
  assign io_bus.evt_valid_o = r_evt_valid;
  assign io_bus.evt_ch_o    = r_evt_ch;
  assign io_bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_pulse_cdc_arbiter.sv
// Self-checking bench for pulse_cdc_arbiter: transaction-level scheduler model plus event scoreboard.
`timescale 1ns/1ps
module tb_pulse_cdc_arbiter;
  import pulse_cdc_arbiter_pkg::*;

  localparam int N_CH        = 4;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CH_W        = ch_w(N_CH);

  logic clka_i   = 1'b0;
  logic clkb_i   = 1'b0;
  logic arst_n_i = 1'b1;
  bit   clkb_run = 1'b1;

  pulse_cdc_arbiter_if #(.N_CH(N_CH), .CH_W(CH_W)) bus_if ();

  pulse_cdc_arbiter #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clka_i   (clka_i),
    .arst_n_i (arst_n_i),
    .clkb_i   (clkb_i),
    .io_bus   (bus_if)
  );

  // clock/reset block: clka 100 MHz, clkb ~37 MHz and stoppable (parks low)
  always #5 clka_i = ~clka_i;
  always begin
    #13.5;
    if (clkb_run || clkb_i) clkb_i = ~clkb_i;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_evt    = 0;
  logic [CH_W-1:0] exp_q[$];
  logic [CH_W-1:0] last_ch = '0;
  int m_ptr = 0;
  int m_cnt[N_CH];
  logic [N_CH-1:0] bvec[4];
  int bk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // model: pending counts per channel, served one at a time in scheduler order
  function automatic bit model_any();
    for (int c = 0; c < N_CH; c++) if (m_cnt[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input int ch);
    exp_q.push_back(CH_W'(ch));
    m_ptr = (ch + 1) % N_CH;
  endtask

  task automatic model_pick();
    int win;
    win = -1;
`ifdef PULSE_CDC_ARB_FIXED_PRIO_EN
    for (int c = N_CH - 1; c >= 0; c--) if (m_cnt[c] > 0) win = c;
`else
    for (int i = N_CH - 1; i >= 0; i--) if (m_cnt[(m_ptr + i) % N_CH] > 0) win = (m_ptr + i) % N_CH;
`endif
    if (win >= 0) begin
      m_cnt[win]--;
      model_push(win);
    end
  endtask

  // Vectors arrive on consecutive cycles; the first grant sees only what arrived before it,
  // every later grant is a full round trip away, after the whole batch is in.
  task automatic model_batch();
    bit started;
    started = 1'b0;
    for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
    for (int j = 0; j < bk; j++) begin
      if (!started && model_any()) begin
        model_pick();
        started = 1'b1;
      end
      for (int c = 0; c < N_CH; c++) if (bvec[j][c]) m_cnt[c]++;
    end
    while (model_any()) model_pick();
  endtask

  function automatic logic [31:0] pack_q();
    logic [31:0] p;
    p = 32'h1;
    foreach (exp_q[i]) p = (p << 4) | 32'(exp_q[i]);
    return p;
  endfunction

  // driver tasks
  task automatic drive_batch();
    for (int j = 0; j < bk; j++) begin
      @(negedge clka_i);
      bus_if.req_i = bvec[j];
    end
    @(negedge clka_i);
    bus_if.req_i = '0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus_if.busy_o) && t < 2000) begin
      @(negedge clka_i);
      t++;
    end
    check({name, "_drain"}, 32'(t < 2000), 32'd1);
    check({name, "_pend"}, 32'(bus_if.pend_o), 32'd0);
  endtask

  task automatic pulse_req(input logic [N_CH-1:0] v);
    @(negedge clka_i);
    bus_if.req_i = v;
    @(negedge clka_i);
    bus_if.req_i = '0;
  endtask

  // scoreboard / compare process
  always @(negedge clkb_i) begin
    if (arst_n_i) begin
      if (bus_if.evt_valid_o) begin
        n_evt++;
        if (exp_q.size() == 0) begin
          check("evt_unexpected", 32'd1, 32'd0);
        end else begin
          logic [CH_W-1:0] e;
          e = exp_q.pop_front();
          check("evt_ch", 32'(bus_if.evt_ch_o), 32'(e));
          last_ch = e;
        end
      end else begin
        check("evt_ch_hold", 32'(bus_if.evt_ch_o), 32'(last_ch));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bus_if.req_i     = '0;
    bus_if.ovf_clr_i = 1'b0;
    #1 arst_n_i = 1'b0;
    #20;
    check("rst_pend", 32'(bus_if.pend_o), 32'd0);
    check("rst_ovf", 32'(bus_if.ovf_o), 32'd0);
    check("rst_busy", 32'(bus_if.busy_o), 32'd0);
    check("rst_evt_valid", 32'(bus_if.evt_valid_o), 32'd0);
    check("rst_evt_ch", 32'(bus_if.evt_ch_o), 32'd0);
    @(negedge clka_i);
    arst_n_i = 1'b1;
    repeat (5) @(negedge clka_i);

    // all four at once from ptr 0
    bvec[0] = 4'b1111; bk = 1;
    model_batch();
    check("pin_all4_order", pack_q(), 32'h10123);
    drive_batch();
    wait_drain("all4");

    // request landing on the cycle of its own grant
    bvec[0] = 4'b0001; bvec[1] = 4'b0001; bk = 2;
    model_batch();
    check("pin_req_grant_order", pack_q(), 32'h100);
    @(negedge clka_i); bus_if.req_i = 4'b0001;
    @(negedge clka_i); bus_if.req_i = 4'b0001;
    @(negedge clka_i); bus_if.req_i = '0;
    check("req_grant_pend", 32'(bus_if.pend_o), 32'h1);
    wait_drain("req_grant");

    // single event on ch 2
    bvec[0] = 4'b0100; bk = 1;
    model_batch();
    check("pin_single_ch2", pack_q(), 32'h12);
    drive_batch();
    wait_drain("single");
    check("single_busy", 32'(bus_if.busy_o), 32'd0);

    // ch0 and ch3 competing repeatedly
    for (int j = 0; j < 4; j++) bvec[j] = 4'b1001;
    bk = 4;
    model_batch();
    drive_batch();
    wait_drain("ch0_ch3");

    // 20 spaced pulses on ch 1
    for (int i = 0; i < 20; i++) begin
      model_push(1);
      pulse_req(4'b0010);
      repeat (5) @(negedge clka_i);
    end
    wait_drain("twenty");
    check("twenty_ovf", 32'(bus_if.ovf_o), 32'd0);

    // saturation while the handshake is stalled
    clkb_run = 1'b0;
    repeat (5) @(negedge clka_i);
    model_push(1);
    pulse_req(4'b0010);
    repeat (8) @(negedge clka_i);
    check("blocked_busy", 32'(bus_if.busy_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clka_i); bus_if.req_i = 4'b0010;
    end
    @(negedge clka_i); bus_if.req_i = '0;
    check("sat_pend", 32'(bus_if.pend_o), 32'h2);
    check("sat_ovf", 32'(bus_if.ovf_o), 32'h2);
    @(negedge clka_i); bus_if.req_i = 4'b0010; bus_if.ovf_clr_i = 1'b1;
    @(negedge clka_i); bus_if.req_i = '0;      bus_if.ovf_clr_i = 1'b0;
    check("ovf_set_wins", 32'(bus_if.ovf_o), 32'h2);
    @(negedge clka_i); bus_if.ovf_clr_i = 1'b1;
    @(negedge clka_i); bus_if.ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(bus_if.ovf_o), 32'd0);
    for (int i = 0; i < 15; i++) model_push(1);
    clkb_run = 1'b1;
    wait_drain("sat");

    // random batches
    for (int b = 0; b < 25; b++) begin
      bk = $urandom_range(1, 4);
      for (int j = 0; j < bk; j++) bvec[j] = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      model_batch();
      drive_batch();
      wait_drain("rand");
    end

    // reset while an event is stuck mid-handshake
    clkb_run = 1'b0;
    repeat (5) @(negedge clka_i);
    pulse_req(4'b1010);
    repeat (8) @(negedge clka_i);
    check("pre_rst_busy", 32'(bus_if.busy_o), 32'd1);
    #3 arst_n_i = 1'b0;
    exp_q.delete();
    m_ptr   = 0;
    last_ch = '0;
    #1;
    check("mid_rst_pend", 32'(bus_if.pend_o), 32'd0);
    check("mid_rst_busy", 32'(bus_if.busy_o), 32'd0);
    check("mid_rst_ovf", 32'(bus_if.ovf_o), 32'd0);
    check("mid_rst_evt_valid", 32'(bus_if.evt_valid_o), 32'd0);
    check("mid_rst_evt_ch", 32'(bus_if.evt_ch_o), 32'd0);
    repeat (3) @(negedge clka_i);
    arst_n_i = 1'b1;
    clkb_run = 1'b1;
    saved = n_evt;
    repeat (100) @(negedge clka_i);
    check("no_evt_after_rst", 32'(n_evt - saved), 32'd0);

    bvec[0] = 4'b0100; bk = 1;
    model_batch();
    drive_batch();
    wait_drain("post_rst");

    repeat (10) @(negedge clka_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
